// File: rtl/uart8051_pkg.sv
// uart8051_pkg: shared states and frame constants for the 8051 serial receiver.
// UART8051_RX_RB8_EN selects 9 data bits per frame instead of 8.
package uart8051_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;
  localparam int UART8051_DATA_W = 8;
`ifdef UART8051_RX_RB8_EN
  localparam int UART8051_NBITS = 9;
`else
  localparam int UART8051_NBITS = 8;
`endif
endpackage

// File: rtl/uart8051_sync.sv
// uart8051_sync: two-flop synchronizer for idle-high serial inputs (resets to 1).
module uart8051_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] s_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) s_q <= 2'b11;
    else s_q <= {s_q[0], d_i};
  assign q_o = s_q[1];
endmodule

// File: rtl/uart8051_rx.sv
// uart8051_rx: 8051 mode-1 serial receiver with valid/ready byte output.
// UART8051_RX_RB8_EN adds a ninth data bit presented on rb8.
module uart8051_rx
  import uart8051_pkg::*;
#(
  parameter int BIT_CYCLES = 16,
  parameter int CNT_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rxd,
  output logic [UART8051_DATA_W-1:0] data,
  output logic                       valid,
  input  logic                       ready,
  output logic                       frame_err,
  output logic                       overrun,
`ifdef UART8051_RX_RB8_EN
  output logic                       rb8,
`endif
  output logic                       busy
);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BIT_CYCLES - 1);
  localparam logic [3:0]       LAST    = 4'(UART8051_NBITS - 1);
  logic                       rx_s, rx_prev_q;
  state_e                     state_q;
  logic [CNT_W-1:0]           tmr_q;
  logic [3:0]                 cnt_q;
  logic [UART8051_NBITS-1:0]  sh_q;
  logic [UART8051_DATA_W-1:0] data_q;
  logic                       valid_q, ferr_q, ovr_q, rb8_q;
  logic                       tick;
  uart8051_sync u_sync (.clk(clk), .rst(rst), .d_i(rxd), .q_o(rx_s));
  assign tick = tmr_q == (state_q == START ? HALF_M1 : FULL_M1);
  // Mid-bit sampling: START counts half a bit, later states a full bit.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      tmr_q     <= '0;
      cnt_q     <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      rb8_q     <= 1'b0;
    end else begin
      rx_prev_q <= rx_s;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      tmr_q     <= tick ? '0 : tmr_q + 1'b1;
      if (valid_q && ready) valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tmr_q <= '0;
          if (rx_prev_q && !rx_s) state_q <= START;
        end
        START: if (tick) begin
          cnt_q   <= '0;
          state_q <= rx_s ? IDLE : DATA;
        end
        DATA: if (tick) begin
          sh_q  <= {rx_s, sh_q[UART8051_NBITS-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= STOP;
        end
        STOP: if (tick) begin
          state_q <= rx_s ? IDLE : WAIT_HIGH;
          ferr_q  <= !rx_s;
          // A byte consumed this very edge frees the slot for the new one.
          if (rx_s && (!valid_q || ready)) begin
            data_q  <= sh_q[UART8051_DATA_W-1:0];
            rb8_q   <= sh_q[UART8051_NBITS-1];
            valid_q <= 1'b1;
          end
          ovr_q <= rx_s && valid_q && !ready;
        end
        WAIT_HIGH: begin
          tmr_q <= '0;
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = state_q != IDLE;
`ifdef UART8051_RX_RB8_EN
  assign rb8 = rb8_q;
`else
  logic unused_rb8;
  assign unused_rb8 = rb8_q;
`endif
endmodule

// File: tb/tb_uart8051_rx.sv
// tb_uart8051_rx: randomized scoreboard bench for uart8051_rx (BIT_CYCLES=16).
module tb_uart8051_rx;
  localparam int BC = 16;
`ifdef UART8051_RX_RB8_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int LAT = 2 + BC / 2 + (NB + 1) * BC + 1;
  typedef struct {
    logic [7:0] d;
    logic       b9;
    int         t;
  } exp_t;
  logic       clk = 0, rst = 0, rxd = 1, ready = 1;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy, rb8_w;
  int tests = 0, fails = 0, cyc = 0;
  int fe_cnt = 0, ov_cnt = 0, exp_fe_t = -1, exp_ov_t = -1;
  logic vprev = 0;
  exp_t exp_q[$];
  uart8051_rx #(.BIT_CYCLES(BC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .data(data), .valid(valid), .ready(ready),
    .frame_err(frame_err), .overrun(overrun),
`ifdef UART8051_RX_RB8_EN
    .rb8(rb8_w),
`endif
    .busy(busy)
  );
`ifndef UART8051_RX_RB8_EN
  assign rb8_w = 1'b0;
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic void chk(string n, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, got, want, cyc);
    end
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      if (valid && !vprev && exp_q.size() > 0 && exp_q[0].t >= 0) chk("valid_latency", cyc, exp_q[0].t);
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_valid: got data %0h expected no byte", data);
        end else begin
          chk("data", data, exp_q[0].d);
          if (NB == 9) chk("rb8", rb8_w, exp_q[0].b9);
          void'(exp_q.pop_front());
        end
      end
      if (frame_err) begin
        fe_cnt++;
        chk("frame_err_time", cyc, exp_fe_t);
      end
      if (overrun) begin
        ov_cnt++;
        chk("overrun_time", cyc, exp_ov_t);
      end
      vprev = valid;
    end else vprev = 0;
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [8:0] v, input logic stop, input logic push, output int t0);
    logic [10:0] fr;
    fr = '1;
    fr[0] = 1'b0;
    fr[NB:1] = v[NB-1:0];
    fr[NB+1] = stop;
    t0 = cyc;
    if (push) exp_q.push_back('{v[7:0], v[8], t0 + LAT});
    for (int i = 0; i <= NB + 1; i++) begin
      rxd = fr[i];
      tick(BC);
    end
  endtask
  initial begin
    int t0, t1, bcnt;
    logic [8:0] v;
    tick(3);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_rb8", rb8_w, 0);
    rst = 1;
    tick(5);
    send(9'h1A5, 1'b1, 1'b1, t0);
    tick(20);
    chk("a5_consumed", exp_q.size(), 0);
    rxd = 0;
    tick(4);
    rxd = 1;
    bcnt = 0;
    for (int i = 0; i < 30; i++) begin
      bcnt += busy;
      tick(1);
    end
    chk("glitch_busy_seen", bcnt > 0, 1);
    chk("glitch_busy_le11", bcnt <= 11, 1);
    chk("glitch_idle", busy, 0);
    exp_fe_t = cyc + LAT;
    send(9'h03C, 1'b0, 1'b0, t0);
    tick(40);
    chk("ferr_count", fe_cnt, 1);
    chk("wait_high_busy", busy, 1);
    chk("ferr_no_valid", valid, 0);
    rxd = 1;
    tick(5);
    chk("wait_high_exit", busy, 0);
    ready = 0;
    send(9'h011, 1'b1, 1'b1, t0);
    exp_ov_t = cyc + LAT;
    send(9'h022, 1'b1, 1'b0, t1);
    tick(20);
    chk("ovr_count", ov_cnt, 1);
    chk("ovr_valid_held", valid, 1);
    chk("ovr_data_kept", data, 8'h11);
    ready = 1;
    tick(3);
    chk("ovr_only_first", valid, 0);
    chk("ovr_queue_empty", exp_q.size(), 0);
    rxd = 0;
    tick(BC);
    for (int i = 0; i < 4; i++) begin
      v = 9'h05A;
      rxd = v[i];
      tick(BC);
    end
    rxd = 1'b1;
    tick(8);
    rst = 0;
    rxd = 1;
    #1;
    chk("midrst_data", data, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ferr", frame_err, 0);
    chk("midrst_ovr", overrun, 0);
    tick(3);
    rst = 1;
    tick(10);
    chk("after_rst_idle", busy, 0);
    send(9'h077, 1'b1, 1'b1, t0);
    tick(5);
    send(9'h181, 1'b1, 1'b1, t0);
    for (int i = 0; i < 20; i++) begin
      v = 9'($urandom_range(0, 511));
      send(v, 1'b1, 1'b1, t0);
      tick($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 20));
    end
    tick(200);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_ferr_count", fe_cnt, 1);
    chk("final_ovr_count", ov_cnt, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
